// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl_if
// Brief    : Bundle between the branch sequencer, main control, ALU and PC.
// Revision : 1.0
// ============================================================================
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       cond_sel;
    logic [31:0]      pc_plus4;
    logic [15:0]      offset;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             alu_gnt;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_gt;
    logic             cnt_clr;

    logic             alu_req;
    logic [2:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic             pc_write;
    logic [31:0]      pc_next;
    logic             busy;
    logic             done;
    logic             taken;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output start, cond_sel, pc_plus4, offset, rs_val, rt_val,
               alu_gnt, alu_result, alu_zero, alu_gt, cnt_clr,
        input  alu_req, alu_op, alu_a, alu_b, pc_write, pc_next,
               busy, done, taken, taken_cnt
    );

    modport slave (
        input  start, cond_sel, pc_plus4, offset, rs_val, rt_val,
               alu_gnt, alu_result, alu_zero, alu_gt, cnt_clr,
        output alu_req, alu_op, alu_a, alu_b, pc_write, pc_next,
               busy, done, taken, taken_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Brief    : Multicycle conditional-branch sequencer sharing the datapath ALU.
// Revision : 1.0
// ============================================================================
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic    clk,
    input  wire logic    reset,
    branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TARGET  = 2'd1,
        S_COMPARE = 2'd2,
        S_RESOLVE = 2'd3
    } state_t;

    localparam logic [2:0]       C_OP_NONE = 3'b000;
    localparam logic [2:0]       C_OP_ADD  = 3'b001;
    localparam logic [2:0]       C_OP_SUB  = 3'b010;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_pc4;
    logic [15:0]      r_off;
    logic [31:0]      r_tgt;
    logic             r_eq;
    logic             r_gt;
    logic             r_taken;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [31:0]      w_off_ext;
    logic             w_cond;
    logic             w_alu_req;
    logic [2:0]       w_alu_op;
    logic [31:0]      w_alu_a;
    logic [31:0]      w_alu_b;
    logic             w_pc_write;
    logic [31:0]      w_pc_next;
    logic             w_done;
    logic             w_taken;

    // Word offset turned into a byte displacement.
    assign w_off_ext = {{14{r_off[15]}}, r_off, 2'b00};

    always_comb begin
        w_cond = 1'b0;
        case (r_sel)
            2'b00:   w_cond = r_eq;
            2'b01:   w_cond = ~r_eq;
            2'b10:   w_cond = ~r_gt;
            default: w_cond = r_gt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= 2'b00;
            r_a         <= '0;
            r_b         <= '0;
            r_pc4       <= '0;
            r_off       <= '0;
            r_tgt       <= '0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_taken     <= 1'b0;
            r_taken_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sel <= bus.cond_sel;
                        r_a   <= bus.rs_val;
                        r_b   <= bus.rt_val;
                        r_pc4 <= bus.pc_plus4;
                        r_off <= bus.offset;
                    end
                end
                S_TARGET: begin
                    if (bus.alu_gnt) r_tgt <= bus.alu_result;
                end
                S_COMPARE: begin
                    if (bus.alu_gnt) begin
                        r_eq <= bus.alu_zero;
                        r_gt <= bus.alu_gt;
                    end
                end
                default: r_taken <= w_cond;
            endcase
            // A clear beats a coincident increment.
            if (bus.cnt_clr) begin
                r_taken_cnt <= '0;
            end else if (r_state == S_RESOLVE && w_cond && r_taken_cnt != C_CNT_MAX) begin
                r_taken_cnt <= r_taken_cnt + C_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alu_req   = 1'b0;
        w_alu_op    = C_OP_NONE;
        w_alu_a     = '0;
        w_alu_b     = '0;
        w_pc_write  = 1'b0;
        w_pc_next   = '0;
        w_done      = 1'b0;
        w_taken     = r_taken;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_TARGET;
            end
            S_TARGET: begin
                w_alu_req = 1'b1;
                w_alu_op  = C_OP_ADD;
                w_alu_a   = r_pc4;
                w_alu_b   = w_off_ext;
                if (bus.alu_gnt) w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                w_alu_req = 1'b1;
                w_alu_op  = C_OP_SUB;
                w_alu_a   = r_a;
                w_alu_b   = r_b;
                if (bus.alu_gnt) w_state_nxt = S_RESOLVE;
            end
            default: begin
                w_done      = 1'b1;
                w_taken     = w_cond;
                w_pc_write  = w_cond;
                w_pc_next   = r_tgt;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.alu_req   = w_alu_req;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_next   = w_pc_next;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = w_done;
    assign bus.taken     = w_taken;
    assign bus.taken_cnt = r_taken_cnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl
// Brief    : Self-checking bench for branch_ctrl with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_branch_ctrl;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    branch_ctrl_if #(.CNT_W(CW)) bus ();
    branch_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural ALU: signed compare flags, wrapping add/sub.
    logic [31:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            3'b001:  alu_res = bus.alu_a + bus.alu_b;
            3'b010:  alu_res = bus.alu_a - bus.alu_b;
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_result = alu_res;
    assign bus.alu_zero   = (alu_res == 32'd0);
    assign bus.alu_gt     = ($signed(bus.alu_a) > $signed(bus.alu_b));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic decide(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return !($signed(a) > $signed(b));
            default: return $signed(a) > $signed(b);
        endcase
    endfunction

    // Model: a branch needs two granted ALU cycles, then one resolve cycle.
    logic          m_valid = 1'b0;
    logic          m_busy  = 1'b0;
    int            m_step  = 0;
    logic          m_taken = 1'b0;
    logic [CW-1:0] m_cnt   = '0;
    logic [1:0]    m_sel   = '0;
    logic [31:0]   m_a     = '0;
    logic [31:0]   m_b     = '0;
    logic [31:0]   m_pc4   = '0;
    logic [31:0]   m_disp  = '0;

    always @(posedge clk) begin : p_model
        logic          dk;
        logic [CW-1:0] nc;
        logic signed [31:0] soff;
        if (reset) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_step  <= 0;
            m_taken <= 1'b0;
            m_cnt   <= '0;
        end else if (m_valid) begin
            nc = m_cnt;
            if (m_busy) begin
                if (m_step < 2) begin
                    if (bus.alu_gnt) m_step <= m_step + 1;
                end else begin
                    dk = decide(m_sel, m_a, m_b);
                    m_taken <= dk;
                    if (dk && m_cnt != {CW{1'b1}}) nc = m_cnt + 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                soff    = $signed(bus.offset);
                m_busy  <= 1'b1;
                m_step  <= 0;
                m_sel   <= bus.cond_sel;
                m_a     <= bus.rs_val;
                m_b     <= bus.rt_val;
                m_pc4   <= bus.pc_plus4;
                m_disp  <= soff * 32'sd4;
            end
            if (bus.cnt_clr) nc = '0;
            m_cnt <= nc;
        end
    end

    always @(negedge clk) begin : p_compare
        logic        rd;
        logic        dk;
        logic [2:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        if (m_valid && !reset) begin
            rd  = m_busy && (m_step == 2);
            dk  = decide(m_sel, m_a, m_b);
            eop = 3'd0;
            ea  = '0;
            eb  = '0;
            if (m_busy && m_step == 0) begin
                eop = 3'd1; ea = m_pc4; eb = m_disp;
            end else if (m_busy && m_step == 1) begin
                eop = 3'd2; ea = m_a; eb = m_b;
            end
            chk("m_busy", bus.busy, m_busy);
            chk("m_done", bus.done, rd);
            chk("m_pc_write", bus.pc_write, rd && dk);
            chk("m_taken", bus.taken, rd ? dk : m_taken);
            if (rd) chk("m_pc_next", bus.pc_next, m_pc4 + m_disp);
            chk("m_alu_req", bus.alu_req, m_busy && m_step < 2);
            chk("m_alu_op", bus.alu_op, eop);
            chk("m_alu_a", bus.alu_a, ea);
            chk("m_alu_b", bus.alu_b, eb);
            chk("m_taken_cnt", bus.taken_cnt, m_cnt);
        end
    end

    function automatic logic gnt_at(input int n, input int ts, input int cs);
        return !((n <= ts) || (n >= ts + 2 && n <= ts + 1 + cs));
    endfunction

    task automatic branch(input logic [1:0] sel, input logic [31:0] pc4, input logic [15:0] off,
                          input logic [31:0] rs, input logic [31:0] rt, input int ts, input int cs,
                          input logic pulse_busy, input logic pulse_res, input logic clr,
                          input logic exp_tk, input logic [31:0] exp_pc, input int exp_lat,
                          input logic [CW-1:0] exp_cnt);
        int n;
        bus.start = 1'b1; bus.cond_sel = sel; bus.pc_plus4 = pc4; bus.offset = off;
        bus.rs_val = rs; bus.rt_val = rt; bus.alu_gnt = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.cond_sel = 2'($urandom); bus.pc_plus4 = $urandom; bus.offset = 16'($urandom);
        bus.rs_val = $urandom; bus.rt_val = $urandom;
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            bus.alu_gnt = gnt_at(n, ts, cs);
            bus.start   = pulse_busy && (n == 1);
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        chk("latency", n, exp_lat);
        chk("taken", bus.taken, exp_tk);
        chk("pc_write", bus.pc_write, exp_tk);
        chk("pc_next", bus.pc_next, exp_pc);
        bus.start = pulse_res; bus.cnt_clr = clr; bus.alu_gnt = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cnt_clr = 1'b0;
        chk("idle_after", bus.busy, 1'b0);
        chk("taken_cnt", bus.taken_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.cond_sel = '0; bus.pc_plus4 = '0; bus.offset = '0;
        bus.rs_val = '0; bus.rt_val = '0; bus.alu_gnt = 1'b1; bus.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_alu_req", bus.alu_req, 1'b0);
        chk("rst_pc_next", bus.pc_next, 32'h0);
        chk("rst_taken_cnt", bus.taken_cnt, 2'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        //     sel    pc4           off       rs            rt            ts cs pb pr clr tk  pc            lat cnt
        branch(2'd0, 32'h100,      16'h0004, 32'd5,        32'd5,        0, 0, 0, 0, 0, 1, 32'h110,      3, 2'd1);
        branch(2'd1, 32'h100,      16'h0004, 32'd7,        32'd7,        0, 0, 0, 0, 0, 0, 32'h110,      3, 2'd1);
        branch(2'd2, 32'h200,      16'h0010, 32'hFFFFFFFF, 32'd1,        0, 0, 1, 0, 0, 1, 32'h240,      3, 2'd2);
        branch(2'd3, 32'h200,      16'h0010, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 1, 0, 0, 32'h240,      3, 2'd2);
        branch(2'd3, 32'h1000,     16'hFFFE, 32'd3,        32'd2,        0, 0, 0, 0, 0, 1, 32'hFF8,      3, 2'd3);
        branch(2'd0, 32'h0,        16'hFFFF, 32'd9,        32'd9,        3, 2, 0, 0, 0, 1, 32'hFFFFFFFC, 8, 2'd3);

        bus.cnt_clr = 1'b1;
        @(posedge clk); #1;
        bus.cnt_clr = 1'b0;
        chk("cnt_clr", bus.taken_cnt, 2'd0);

        branch(2'd0, 32'h40,       16'h0001, 32'd1,        32'd1,        0, 0, 0, 0, 0, 1, 32'h44,       3, 2'd1);
        branch(2'd2, 32'h40,       16'h0002, 32'd4,        32'd4,        1, 0, 0, 0, 0, 1, 32'h48,       4, 2'd2);
        branch(2'd1, 32'hFFFFFFFC, 16'h0001, 32'd0,        32'd8,        0, 1, 0, 0, 0, 1, 32'h0,        4, 2'd3);
        branch(2'd3, 32'h40,       16'h0003, 32'd9,        32'hFFFFFFF0, 0, 0, 0, 0, 0, 1, 32'h4C,       3, 2'd3);
        branch(2'd0, 32'h80,       16'h0000, 32'd2,        32'd2,        0, 0, 0, 0, 1, 1, 32'h80,       3, 2'd0);
        branch(2'd0, 32'h80,       16'h0000, 32'd2,        32'd2,        0, 0, 0, 0, 0, 1, 32'h80,       3, 2'd1);

        // Abort from COMPARE.
        bus.start = 1'b1; bus.cond_sel = 2'd0; bus.pc_plus4 = 32'h300; bus.offset = 16'h1;
        bus.rs_val = 32'd6; bus.rt_val = 32'd6; bus.alu_gnt = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_compare", bus.alu_op, 3'b010);
        bus.alu_gnt = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.alu_gnt = 1'b1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_pc_write", bus.pc_write, 1'b0);
        chk("abort_taken_cnt", bus.taken_cnt, 2'd0);
        repeat (4) @(posedge clk);
        #1;

        branch(2'd3, 32'h500,      16'h8000, 32'd10,       32'd1,        0, 0, 0, 0, 0, 1, 32'hFFFE0500, 3, 2'd1);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
